// File: rtl/sdp_nrdma_eg_dout_unpack_pkg.sv
// Shared types and sizing helpers for the SDP NRDMA egress read-order data unpacker.
// Optional stall counter macro: SDP_NRDMA_EG_UNPACK_PERF_EN.
package sdp_nrdma_eg_dout_unpack_pkg;

  localparam int DEF_IN_W  = 256;
  localparam int DEF_OUT_W = 64;
  localparam int DEF_CNT_W = 13;
  localparam int PERF_W    = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int calc_ratio(input int in_w, input int out_w);
    return in_w / out_w;
  endfunction

  // Slice index needs at least one bit even when a beat is a single slice.
  function automatic int idx_width(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/sdp_nrdma_eg_slice_sel.sv
// Combinational slice mux: picks the OUT_W-wide slice of the holding register
// addressed by the slice index; slice 0 is the LSB slice.
module sdp_nrdma_eg_slice_sel #(
  parameter int IN_W   = 256,
  parameter int OUT_W  = 64,
  parameter int RATIO  = 4,
  parameter int SIDX_W = 2
) (
  input  logic [IN_W-1:0]   i_hold,
  input  logic [SIDX_W-1:0] i_slice_idx,
  output logic [OUT_W-1:0]  o_slice
);

  always_comb begin
    // NOTE: the default assignment before the loop keeps this purely combinational; without it an unmatched index would infer a latch.
    o_slice = i_hold[OUT_W-1:0];
    for (int s = 1; s < RATIO; s++) begin
      if (i_slice_idx == SIDX_W'(s)) o_slice = i_hold[s*OUT_W +: OUT_W];
    end
  end

endmodule

// File: rtl/sdp_nrdma_eg_dout_unpack.sv
// Unpacks IN_W-wide read-order FIFO beats into OUT_W slices, counts beats per layer,
// flags the final slice and pulses layer_done. Macro SDP_NRDMA_EG_UNPACK_PERF_EN adds perf_stall_cnt.
module sdp_nrdma_eg_dout_unpack
  import sdp_nrdma_eg_dout_unpack_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rstn,
  input  logic             op_en,
  input  logic [CNT_W-1:0] cfg_beat_num,
  input  logic             rod_rd_pvld,
  output logic             rod_rd_prdy,
  input  logic [IN_W-1:0]  rod_rd_pd,
  output logic             dp_pvld,
  input  logic             dp_prdy,
  output logic [OUT_W-1:0] dp_pd,
  output logic             dp_last,
  output logic             layer_done
`ifdef SDP_NRDMA_EG_UNPACK_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_stall_cnt
`endif
);

  localparam int RATIO  = calc_ratio(IN_W, OUT_W);
  localparam int SIDX_W = idx_width(RATIO);
  localparam logic [SIDX_W-1:0] LAST_IDX = SIDX_W'(RATIO - 1);

  state_e             r_state;
  logic [CNT_W-1:0]   r_cfg_beat_num;
  logic [CNT_W-1:0]   r_beat_cnt;
  logic [SIDX_W-1:0]  r_slice_idx;
  logic               r_full;
  logic               r_last_beat_loaded;
  logic [IN_W-1:0]    r_hold;

  logic               w_on_last_idx;
  logic               w_slice_acc;
  logic               w_beat_end;
  logic               w_layer_end;
  logic               w_beat_acc;
  logic [CNT_W-1:0]   w_load_idx;

  assign w_on_last_idx = (r_slice_idx == LAST_IDX);
  assign w_slice_acc   = r_full && dp_prdy;
  assign w_beat_end    = w_slice_acc && w_on_last_idx;
  assign w_layer_end   = w_beat_end && (r_beat_cnt == r_cfg_beat_num);

  // A new beat may enter while the last slice of the current one drains, giving no bubble.
  assign rod_rd_prdy = (r_state == ST_RUN)
                    && (!r_full || (w_on_last_idx && dp_prdy))
                    && !r_last_beat_loaded;
  assign w_beat_acc  = rod_rd_pvld && rod_rd_prdy;

  // A reload happens only while the current beat completes, so the incoming beat is one further on.
  assign w_load_idx = r_full ? (r_beat_cnt + CNT_W'(1)) : r_beat_cnt;

  always_ff @(posedge nvdla_core_clk) begin
    // NOTE: reset is sampled on the clock edge and also clears the wide holding register, so a beat held when reset hits is discarded and dp_pd reads zero.
    if (!nvdla_core_rstn) begin
      r_state            <= ST_IDLE;
      r_cfg_beat_num     <= '0;
      r_beat_cnt         <= '0;
      r_slice_idx        <= '0;
      r_full             <= 1'b0;
      r_last_beat_loaded <= 1'b0;
      r_hold             <= '0;
    end else begin
      // NOTE: every register here uses <= so all updates see the pre-edge values of their neighbours.
      case (r_state)
        ST_IDLE: begin
          if (op_en) begin
            r_state            <= ST_RUN;
            r_cfg_beat_num     <= cfg_beat_num;
            r_beat_cnt         <= '0;
            r_slice_idx        <= '0;
            r_full             <= 1'b0;
            r_last_beat_loaded <= 1'b0;
          end
        end
        ST_RUN: begin
          if (w_beat_end) r_beat_cnt <= r_beat_cnt + CNT_W'(1);
          if (w_beat_acc) begin
            r_hold      <= rod_rd_pd;
            r_full      <= 1'b1;
            r_slice_idx <= '0;
            if (w_load_idx == r_cfg_beat_num) r_last_beat_loaded <= 1'b1;
          end else if (w_slice_acc) begin
            if (w_on_last_idx) r_full <= 1'b0;
            else               r_slice_idx <= r_slice_idx + SIDX_W'(1);
          end
          if (w_layer_end) r_state <= ST_DONE;
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  sdp_nrdma_eg_slice_sel #(
    .IN_W   (IN_W),
    .OUT_W  (OUT_W),
    .RATIO  (RATIO),
    .SIDX_W (SIDX_W)
  ) u_slice_sel (
    .i_hold      (r_hold),
    .i_slice_idx (r_slice_idx),
    .o_slice     (dp_pd)
  );

  assign dp_pvld    = r_full;
  assign dp_last    = r_full && w_on_last_idx && (r_beat_cnt == r_cfg_beat_num);
  assign layer_done = (r_state == ST_DONE);

`ifdef SDP_NRDMA_EG_UNPACK_PERF_EN
  logic [PERF_W-1:0] r_perf_stall_cnt;

  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      r_perf_stall_cnt <= '0;
    end else if ((r_state == ST_IDLE) && op_en) begin
      r_perf_stall_cnt <= '0;
    end else if ((r_state == ST_RUN) && r_full && !dp_prdy && (r_perf_stall_cnt != '1)) begin
      r_perf_stall_cnt <= r_perf_stall_cnt + PERF_W'(1);
    end
  end

  assign perf_stall_cnt = r_perf_stall_cnt;
`endif

endmodule

// File: tb/tb_sdp_nrdma_eg_dout_unpack.sv
// Self-checking bench for sdp_nrdma_eg_dout_unpack: default 256->64 instance plus a
// 256->256 instance for the full-range beat counter. Honours SDP_NRDMA_EG_UNPACK_PERF_EN.
module tb_sdp_nrdma_eg_dout_unpack;

  localparam int IN_W  = 256;
  localparam int OUT_W = 64;
  localparam int CNT_W = 13;
  localparam int RATIO = IN_W / OUT_W;

  logic nvdla_core_clk = 1'b0;
  always #5 nvdla_core_clk = ~nvdla_core_clk;

  logic             nvdla_core_rstn;
  logic             op_en;
  logic [CNT_W-1:0] cfg_beat_num;
  logic             rod_rd_pvld;
  logic             rod_rd_prdy;
  logic [IN_W-1:0]  rod_rd_pd;
  logic             dp_pvld;
  logic             dp_prdy;
  logic [OUT_W-1:0] dp_pd;
  logic             dp_last;
  logic             layer_done;

  logic             x_op_en;
  logic [CNT_W-1:0] x_cfg_beat_num;
  logic             x_rod_rd_pvld;
  logic             x_rod_rd_prdy;
  logic [IN_W-1:0]  x_rod_rd_pd;
  logic             x_dp_pvld;
  logic             x_dp_prdy;
  logic [IN_W-1:0]  x_dp_pd;
  logic             x_dp_last;
  logic             x_layer_done;

`ifdef SDP_NRDMA_EG_UNPACK_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] x_perf_stall_cnt;
`endif

  sdp_nrdma_eg_dout_unpack #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
    .nvdla_core_clk  (nvdla_core_clk),
    .nvdla_core_rstn (nvdla_core_rstn),
    .op_en           (op_en),
    .cfg_beat_num    (cfg_beat_num),
    .rod_rd_pvld     (rod_rd_pvld),
    .rod_rd_prdy     (rod_rd_prdy),
    .rod_rd_pd       (rod_rd_pd),
    .dp_pvld         (dp_pvld),
    .dp_prdy         (dp_prdy),
    .dp_pd           (dp_pd),
    .dp_last         (dp_last),
    .layer_done      (layer_done)
`ifdef SDP_NRDMA_EG_UNPACK_PERF_EN
    ,
    .perf_stall_cnt  (perf_stall_cnt)
`endif
  );

  sdp_nrdma_eg_dout_unpack #(.IN_W(IN_W), .OUT_W(IN_W), .CNT_W(CNT_W)) dut_x (
    .nvdla_core_clk  (nvdla_core_clk),
    .nvdla_core_rstn (nvdla_core_rstn),
    .op_en           (x_op_en),
    .cfg_beat_num    (x_cfg_beat_num),
    .rod_rd_pvld     (x_rod_rd_pvld),
    .rod_rd_prdy     (x_rod_rd_prdy),
    .rod_rd_pd       (x_rod_rd_pd),
    .dp_pvld         (x_dp_pvld),
    .dp_prdy         (x_dp_prdy),
    .dp_pd           (x_dp_pd),
    .dp_last         (x_dp_last),
    .layer_done      (x_layer_done)
`ifdef SDP_NRDMA_EG_UNPACK_PERF_EN
    ,
    .perf_stall_cnt  (x_perf_stall_cnt)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_pd(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [IN_W-1:0] rand_beat();
    logic [IN_W-1:0] b;
    for (int i = 0; i < IN_W/32; i++) b[i*32 +: 32] = $urandom();
    return b;
  endfunction

  // Reference model: every accepted beat expands into RATIO expected slices, LSB first;
  // the final slice of beat number cfg is the layer's last slice.
  logic [OUT_W-1:0] exp_q[$];
  bit               exp_last_q[$];
  int  cyc = 0;
  int  cfg_m, beats_loaded, n_slices, n_acc, n_stall;
  int  last_fire_cyc, last_acc_cyc, first_slice_cyc;
  int  prdy_mode, pvld_mode;
  bit  strict, prev_stall, need_pd;
  logic [OUT_W-1:0] prev_pd;

  task automatic observe();
    logic [OUT_W-1:0] e_pd;
    bit e_last;
    cyc++;
    if (prev_stall) begin
      check_bit("stall_hold_valid", dp_pvld, 1'b1);
      check_pd("stall_hold_pd", dp_pd, prev_pd);
    end
    if (dp_pvld && dp_prdy) begin
      if (exp_q.size() == 0) begin
        check_int("spurious_slice", 1, 0);
      end else begin
        e_pd   = exp_q.pop_front();
        e_last = exp_last_q.pop_front();
        check_pd("slice_pd", dp_pd, e_pd);
        check_bit("slice_last", dp_last, e_last);
        if (e_last) last_fire_cyc = cyc;
      end
      if (strict) begin
        if (n_slices == 0) first_slice_cyc = cyc;
        else check_int("slice_gap", cyc - first_slice_cyc, n_slices);
      end
      n_slices++;
    end
    if (beats_loaded > cfg_m) check_bit("prdy_after_last", rod_rd_prdy, 1'b0);
    if (rod_rd_pvld && rod_rd_prdy) begin
      if (strict && n_acc > 0) check_int("accept_gap", cyc - last_acc_cyc, RATIO);
      for (int s = 0; s < RATIO; s++) begin
        exp_q.push_back(rod_rd_pd[s*OUT_W +: OUT_W]);
        exp_last_q.push_back((beats_loaded == cfg_m) && (s == RATIO-1));
      end
      beats_loaded++;
      n_acc++;
      last_acc_cyc = cyc;
      need_pd = 1'b1;
    end
    check_bit("layer_done", layer_done, cyc == last_fire_cyc + 1);
    prev_stall = dp_pvld && !dp_prdy;
    if (prev_stall) n_stall++;
    prev_pd = dp_pd;
  endtask

  task automatic drive();
    case (prdy_mode)
      0:       dp_prdy = 1'b1;
      1:       dp_prdy = ~dp_prdy;
      default: dp_prdy = 1'($urandom_range(0, 1));
    endcase
    if (need_pd) begin
      rod_rd_pd   = rand_beat();
      rod_rd_pvld = (pvld_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      need_pd     = 1'b0;
    end else if (!rod_rd_pvld) begin
      rod_rd_pvld = (pvld_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end
  endtask

  // Called just after a rising edge; returns just after the edge that lands in IDLE.
  task automatic run_layer(input int cfg, input int pm, input int vm, input bit reop,
                           input int exp_slices, input int exp_acc, input int budget);
    bit done;
    done = 1'b0;
    exp_q.delete();
    exp_last_q.delete();
    cfg_m = cfg; beats_loaded = 0; n_slices = 0; n_acc = 0; n_stall = 0;
    prev_stall = 1'b0; last_fire_cyc = -100;
    prdy_mode = pm; pvld_mode = vm; strict = (pm == 0) && (vm == 0);
    op_en = 1'b1;
    cfg_beat_num = CNT_W'(cfg);
    drive();
    @(negedge nvdla_core_clk);
    check_bit("prdy_on_op_cycle", rod_rd_prdy, 1'b0);
    observe();
    for (int c = 0; c < budget && !done; c++) begin
      @(posedge nvdla_core_clk); #1;
      op_en        = reop && (c == 3);
      cfg_beat_num = CNT_W'(cfg + 4);
      drive();
      @(negedge nvdla_core_clk);
      observe();
      if (cyc == last_fire_cyc + 1) done = 1'b1;
    end
    @(posedge nvdla_core_clk); #1;
    op_en = 1'b0;
    if (!done) check_int("layer_timeout", 0, 1);
    check_int("n_slices", n_slices, exp_slices);
    check_int("n_accepts", n_acc, exp_acc);
    check_int("model_queue_empty", exp_q.size(), 0);
`ifdef SDP_NRDMA_EG_UNPACK_PERF_EN
    check_int("perf_stall_cnt", int'(perf_stall_cnt), n_stall);
`endif
  endtask

  typedef struct {
    int cfg;
    int pm;
    int vm;
    int exp_slices;
    int exp_acc;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [IN_W-1:0] p;
    int got, errs, last_pos, x_acc;
    bit done_seen, acc;

    vecs[0] = '{cfg: 0, pm: 0, vm: 0, exp_slices: 4,  exp_acc: 1};
    vecs[1] = '{cfg: 7, pm: 0, vm: 0, exp_slices: 32, exp_acc: 8};
    vecs[2] = '{cfg: 3, pm: 1, vm: 0, exp_slices: 16, exp_acc: 4};
    vecs[3] = '{cfg: 5, pm: 2, vm: 2, exp_slices: 24, exp_acc: 6};
    vecs[4] = '{cfg: 2, pm: 2, vm: 0, exp_slices: 12, exp_acc: 3};
    vecs[5] = '{cfg: 1, pm: 1, vm: 2, exp_slices: 8,  exp_acc: 2};

    nvdla_core_rstn = 1'b0;
    op_en = 1'b0; cfg_beat_num = '0; rod_rd_pvld = 1'b0; rod_rd_pd = '0; dp_prdy = 1'b1;
    x_op_en = 1'b0; x_cfg_beat_num = '0; x_rod_rd_pvld = 1'b0; x_rod_rd_pd = '0; x_dp_prdy = 1'b1;
    need_pd = 1'b0;
    repeat (3) @(posedge nvdla_core_clk);
    @(negedge nvdla_core_clk);
    check_bit("rst_prdy", rod_rd_prdy, 1'b0);
    check_bit("rst_pvld", dp_pvld, 1'b0);
    check_pd("rst_pd", dp_pd, '0);
    check_bit("rst_last", dp_last, 1'b0);
    check_bit("rst_done", layer_done, 1'b0);
`ifdef SDP_NRDMA_EG_UNPACK_PERF_EN
    check_int("rst_perf", int'(perf_stall_cnt), 0);
`endif
    @(posedge nvdla_core_clk); #1;
    nvdla_core_rstn = 1'b1;

    // Basic layer: exact cycle timing of a single beat.
    p = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
         64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    op_en = 1'b1; cfg_beat_num = '0; rod_rd_pvld = 1'b1; rod_rd_pd = p; dp_prdy = 1'b1;
    @(negedge nvdla_core_clk);
    check_bit("basic_prdy_op", rod_rd_prdy, 1'b0);
    @(posedge nvdla_core_clk); #1;
    op_en = 1'b0;
    @(negedge nvdla_core_clk);
    check_bit("basic_prdy_n1", rod_rd_prdy, 1'b1);
    check_bit("basic_pvld_n1", dp_pvld, 1'b0);
    @(posedge nvdla_core_clk); #1;
    rod_rd_pd = rand_beat();
    for (int k = 0; k < RATIO; k++) begin
      @(negedge nvdla_core_clk);
      check_bit("basic_pvld", dp_pvld, 1'b1);
      check_pd("basic_pd", dp_pd, p[k*OUT_W +: OUT_W]);
      check_bit("basic_last", dp_last, k == RATIO-1);
      check_bit("basic_prdy_hold", rod_rd_prdy, 1'b0);
      check_bit("basic_done_early", layer_done, 1'b0);
      @(posedge nvdla_core_clk); #1;
    end
    @(negedge nvdla_core_clk);
    check_bit("basic_done", layer_done, 1'b1);
    check_bit("basic_pvld_off", dp_pvld, 1'b0);
    @(posedge nvdla_core_clk); #1;
    @(negedge nvdla_core_clk);
    check_bit("basic_done_pulse", layer_done, 1'b0);
    @(posedge nvdla_core_clk); #1;

    // Table-driven layers with random payloads, backpressure and valid gaps.
    for (int v = 0; v < 6; v++)
      run_layer(vecs[v].cfg, vecs[v].pm, vecs[v].vm, 1'b0, vecs[v].exp_slices, vecs[v].exp_acc, 400);

    // Gating: valid held in IDLE is not accepted; op_en during RUN is ignored.
    rod_rd_pvld = 1'b1;
    repeat (3) begin
      @(negedge nvdla_core_clk);
      check_bit("idle_gate", rod_rd_prdy, 1'b0);
      @(posedge nvdla_core_clk); #1;
    end
    run_layer(1, 0, 0, 1'b1, 8, 2, 200);

    // Reset mid-layer after two of four slices.
    p = rand_beat();
    op_en = 1'b1; cfg_beat_num = '0; rod_rd_pvld = 1'b1; rod_rd_pd = p; dp_prdy = 1'b1;
    @(posedge nvdla_core_clk); #1;
    op_en = 1'b0;
    @(posedge nvdla_core_clk); #1;
    rod_rd_pvld = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge nvdla_core_clk);
      check_pd("mid_pd", dp_pd, p[k*OUT_W +: OUT_W]);
      @(posedge nvdla_core_clk); #1;
    end
    nvdla_core_rstn = 1'b0;
    @(posedge nvdla_core_clk); #1;
    @(negedge nvdla_core_clk);
    check_bit("mrst_prdy", rod_rd_prdy, 1'b0);
    check_bit("mrst_pvld", dp_pvld, 1'b0);
    check_pd("mrst_pd", dp_pd, '0);
    check_bit("mrst_last", dp_last, 1'b0);
    check_bit("mrst_done", layer_done, 1'b0);
`ifdef SDP_NRDMA_EG_UNPACK_PERF_EN
    check_int("mrst_perf", int'(perf_stall_cnt), 0);
`endif
    @(posedge nvdla_core_clk); #1;
    nvdla_core_rstn = 1'b1;
    need_pd = 1'b1;
    run_layer(1, 0, 0, 1'b0, 8, 2, 200);
    rod_rd_pvld = 1'b0;

    // Full-range beat counter on the single-slice instance.
    x_op_en = 1'b1; x_cfg_beat_num = CNT_W'(13'h1FFF); x_rod_rd_pvld = 1'b1; x_rod_rd_pd = '0; x_dp_prdy = 1'b1;
    @(posedge nvdla_core_clk); #1;
    x_op_en = 1'b0;
    got = 0; errs = 0; last_pos = -1; x_acc = 0; done_seen = 1'b0;
    for (int c = 0; c < 8400 && !done_seen; c++) begin
      @(negedge nvdla_core_clk);
      if (x_dp_pvld && x_dp_prdy) begin
        if (x_dp_pd !== IN_W'(got)) errs++;
        if (x_dp_last) begin
          if (last_pos < 0) last_pos = got;
          else errs++;
        end
        got++;
      end
      if (x_layer_done) done_seen = 1'b1;
      acc = x_rod_rd_pvld && x_rod_rd_prdy;
      if (acc) x_acc++;
      @(posedge nvdla_core_clk); #1;
      if (acc) x_rod_rd_pd = x_rod_rd_pd + IN_W'(1);
    end
    @(negedge nvdla_core_clk);
    check_bit("x_prdy_after", x_rod_rd_prdy, 1'b0);
    check_int("x_slices", got, 8192);
    check_int("x_accepts", x_acc, 8192);
    check_int("x_last_pos", last_pos, 8191);
    check_int("x_order_errs", errs, 0);
    check_bit("x_done_seen", done_seen, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
